// File: rtl/sc_nivelctrl_pkg.sv
// Shared definitions for the Frogger level/lives controller and the blocks that
// consume its level bus (lane registers, display logic).
package sc_nivelctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_ADVANCE  = 3'd3;
  localparam logic [2:0] ST_RELOAD   = 3'd4;
  localparam logic [2:0] ST_GAMEOVER = 3'd5;
  localparam logic [2:0] ST_WIN      = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    INIT     = ST_INIT,
    PLAY     = ST_PLAY,
    ADVANCE  = ST_ADVANCE,
    RELOAD   = ST_RELOAD,
    GAMEOVER = ST_GAMEOVER,
    WIN      = ST_WIN
  } state_t;

  localparam int DATAWIDTH_NVL_DEF       = 2;
  localparam int DATAWIDTH_LIVES_DEF     = 2;
  localparam int DATAWIDTH_GOALS_DEF     = 2;
  localparam int NVL_MAX                 = 2**DATAWIDTH_NVL_DEF - 1;
  localparam int LIVES_INIT_DEF          = 3;
  localparam int GOALS_PER_LEVEL_DEF     = 3;

  // States in which the lanes must reload their pattern and speed.
  function automatic logic cn_state(input state_t s);
    return (s == INIT) || (s == ADVANCE) || (s == RELOAD);
  endfunction

endpackage

// File: rtl/sc_nivelctrl_edgedetect.sv
// Rising-edge detector for the start button; the history register resets to 1
// so a button held through reset does not count as a press.
module sc_nivelctrl_edgedetect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q <= 1'b1;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/sc_nivelctrl.sv
// Level/lives controller for the Frogger vehicle lanes: turns goal/hit/start
// events into the level bus, the lane reload strobe and game status flags.
module sc_nivelctrl
  import sc_nivelctrl_pkg::*;
#(
  parameter int DATAWIDTH_NVL   = DATAWIDTH_NVL_DEF,
  parameter int DATAWIDTH_LIVES = DATAWIDTH_LIVES_DEF,
  parameter int DATAWIDTH_GOALS = DATAWIDTH_GOALS_DEF,
  parameter int LIVES_INIT      = LIVES_INIT_DEF,
  parameter int GOALS_PER_LEVEL = GOALS_PER_LEVEL_DEF
) (
  input  logic                       SC_NIVELCTRL_CLOCK_50,
  input  logic                       SC_NIVELCTRL_RESET,
  input  logic                       SC_NIVELCTRL_START_IN,
  input  logic                       SC_NIVELCTRL_GOAL_IN,
  input  logic                       SC_NIVELCTRL_HIT_IN,
  output logic [DATAWIDTH_NVL-1:0]   SC_NIVELCTRL_NVL_OUT,
  output logic                       SC_NIVELCTRL_CN_OUT,
  output logic [DATAWIDTH_LIVES-1:0] SC_NIVELCTRL_LIVES_OUT,
  output logic [DATAWIDTH_GOALS-1:0] SC_NIVELCTRL_GOALS_OUT,
  output logic                       SC_NIVELCTRL_PLAYING_OUT,
  output logic                       SC_NIVELCTRL_GAMEOVER_OUT,
  output logic                       SC_NIVELCTRL_WIN_OUT
);

  localparam logic [DATAWIDTH_NVL-1:0]   NVL_TOP    = '1;
  localparam logic [DATAWIDTH_LIVES-1:0] LIVES_LOAD = DATAWIDTH_LIVES'(LIVES_INIT);
  localparam logic [DATAWIDTH_LIVES-1:0] LIVES_ONE  = DATAWIDTH_LIVES'(1);
  localparam logic [DATAWIDTH_GOALS-1:0] GOALS_DONE = DATAWIDTH_GOALS'(GOALS_PER_LEVEL);

  generate
    if (LIVES_INIT < 1 || LIVES_INIT > 2**DATAWIDTH_LIVES - 1) begin : g_bad_lives
      $error("LIVES_INIT out of range for DATAWIDTH_LIVES");
    end
    if (GOALS_PER_LEVEL < 1 || GOALS_PER_LEVEL > 2**DATAWIDTH_GOALS - 1) begin : g_bad_goals
      $error("GOALS_PER_LEVEL out of range for DATAWIDTH_GOALS");
    end
  endgenerate

  logic clk;
  logic rst_n;
  logic start_rise;

  assign clk   = SC_NIVELCTRL_CLOCK_50;
  assign rst_n = SC_NIVELCTRL_RESET;

  sc_nivelctrl_edgedetect u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SC_NIVELCTRL_START_IN),
    .rise  (start_rise)
  );

  state_t                     state;
  state_t                     state_nxt;
  logic [DATAWIDTH_NVL-1:0]   nvl;
  logic [DATAWIDTH_NVL-1:0]   nvl_nxt;
  logic [DATAWIDTH_LIVES-1:0] lives;
  logic [DATAWIDTH_LIVES-1:0] lives_nxt;
  logic [DATAWIDTH_GOALS-1:0] goals;
  logic [DATAWIDTH_GOALS-1:0] goals_nxt;
  logic [DATAWIDTH_GOALS-1:0] goals_inc;
  logic [DATAWIDTH_NVL-1:0]   nvl_inc;
  logic [DATAWIDTH_LIVES-1:0] lives_dec;

  // No wrap is possible: goals clear at the target, level caps via WIN, lives stop via GAMEOVER.
  assign goals_inc = goals + 1'b1;
  assign nvl_inc   = nvl + 1'b1;
  assign lives_dec = lives - 1'b1;

  always_comb begin
    state_nxt = state;
    nvl_nxt   = nvl;
    lives_nxt = lives;
    goals_nxt = goals;
    case (state)
      IDLE, GAMEOVER, WIN: begin
        if (start_rise) begin
          state_nxt = INIT;
          nvl_nxt   = '0;
          lives_nxt = LIVES_LOAD;
          goals_nxt = '0;
        end
      end
      INIT, ADVANCE, RELOAD: begin
        state_nxt = PLAY;
      end
      PLAY: begin
        // A collision wins over a goal arriving in the same cycle.
        if (SC_NIVELCTRL_HIT_IN) begin
          if (lives == LIVES_ONE) begin
            state_nxt = GAMEOVER;
            lives_nxt = '0;
          end else begin
            state_nxt = RELOAD;
            lives_nxt = lives_dec;
          end
        end else if (SC_NIVELCTRL_GOAL_IN) begin
          if (goals_inc != GOALS_DONE) begin
            goals_nxt = goals_inc;
          end else if (nvl == NVL_TOP) begin
            state_nxt = WIN;
            goals_nxt = '0;
          end else begin
            state_nxt = ADVANCE;
            nvl_nxt   = nvl_inc;
            goals_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= IDLE;
      nvl                       <= '0;
      lives                     <= LIVES_LOAD;
      goals                     <= '0;
      SC_NIVELCTRL_CN_OUT       <= 1'b0;
      SC_NIVELCTRL_PLAYING_OUT  <= 1'b0;
      SC_NIVELCTRL_GAMEOVER_OUT <= 1'b0;
      SC_NIVELCTRL_WIN_OUT      <= 1'b0;
    end else begin
      state                     <= state_nxt;
      nvl                       <= nvl_nxt;
      lives                     <= lives_nxt;
      goals                     <= goals_nxt;
      SC_NIVELCTRL_CN_OUT       <= cn_state(state_nxt);
      SC_NIVELCTRL_PLAYING_OUT  <= (state_nxt == PLAY);
      SC_NIVELCTRL_GAMEOVER_OUT <= (state_nxt == GAMEOVER);
      SC_NIVELCTRL_WIN_OUT      <= (state_nxt == WIN);
    end
  end

  assign SC_NIVELCTRL_NVL_OUT   = nvl;
  assign SC_NIVELCTRL_LIVES_OUT = lives;
  assign SC_NIVELCTRL_GOALS_OUT = goals;

endmodule

// File: doc/sc_nivelctrl.md
# sc_nivelctrl

Level/lives controller for the vehicle lanes of the Frogger game. Sits directly upstream of every lane register. Converts frog events (goal reached, collision) and the player start button into:
- the 2-bit level bus (`NVL`) and one-cycle level-change strobe (`CN`) that every lane register consumes to reload its pattern and speed;
- lives, goals and game-state status for the display logic.

## Interface
Parameters:
- `DATAWIDTH_NVL`, 2, width of level bus; levels 0..2^W-1.
- `DATAWIDTH_LIVES`, 2, width of lives counter.
- `DATAWIDTH_GOALS`, 2, width of goals-in-level counter.
- `LIVES_INIT`, 3, lives loaded at game start; must be 1..2^DATAWIDTH_LIVES-1.
- `GOALS_PER_LEVEL`, 3, goals needed to advance; must be 1..2^DATAWIDTH_GOALS-1.

Ports (clock and reset first). One clock; reset is synchronous and active-low.
- `SC_NIVELCTRL_CLOCK_50`, in, 1, system clock; all state on rising edge.
- `SC_NIVELCTRL_RESET`, in, 1, synchronous, active-low.
- `SC_NIVELCTRL_START_IN`, in, 1, start button level, already synchronised/debounced.
- `SC_NIVELCTRL_GOAL_IN`, in, 1, one-cycle pulse: frog reached top row.
- `SC_NIVELCTRL_HIT_IN`, in, 1, one-cycle pulse: frog collided with a vehicle.
- `SC_NIVELCTRL_NVL_OUT`, out, DATAWIDTH_NVL, current level; feeds lane `NVL_IN`.
- `SC_NIVELCTRL_CN_OUT`, out, 1, one-cycle level-change/reload strobe; feeds lane `CN_IN`.
- `SC_NIVELCTRL_LIVES_OUT`, out, DATAWIDTH_LIVES, remaining lives.
- `SC_NIVELCTRL_GOALS_OUT`, out, DATAWIDTH_GOALS, goals scored in current level.
- `SC_NIVELCTRL_PLAYING_OUT`, out, 1, high in PLAY state only.
- `SC_NIVELCTRL_GAMEOVER_OUT`, out, 1, high in GAMEOVER state.
- `SC_NIVELCTRL_WIN_OUT`, out, 1, high in WIN state.

## Operation
- Start edge: `start_rise = START_IN & ~start_q`.
  - `start_q` resets to 1, so a button held through reset must be released and pressed again.
- States: IDLE, INIT, PLAY, ADVANCE, RELOAD, GAMEOVER, WIN. All outputs are Moore (registered).
- **IDLE**: `start_rise` -> INIT.
- **INIT**: one cycle.
  - NVL=0, lives=LIVES_INIT, goals=0, CN=1.
  - -> PLAY.
- **PLAY**: PLAYING=1.
  - HIT has priority over GOAL when both arrive in the same cycle.
  - HIT with lives==1 -> GAMEOVER, lives=0.
  - HIT with lives>1 -> RELOAD, lives-1.
  - GOAL with goals+1<GOALS_PER_LEVEL -> goals+1, stay in PLAY, no CN.
  - GOAL with goals+1==GOALS_PER_LEVEL and NVL==max -> WIN, goals=0.
  - GOAL with goals+1==GOALS_PER_LEVEL and NVL<max -> ADVANCE, NVL+1, goals=0.
- **ADVANCE**: one cycle, CN=1 -> PLAY.
- **RELOAD**: one cycle, CN=1, NVL unchanged (lanes restart the same level) -> PLAY.
- **GAMEOVER / WIN**: hold all counters; `start_rise` -> INIT.
- GOAL, HIT and START are ignored in any state where no transition is listed above, including INIT, ADVANCE and RELOAD.
- Counter arithmetic is unsigned. No wrap can occur: level is capped via the WIN path, lives stop at 0 via GAMEOVER, goals clear at GOALS_PER_LEVEL.

## Timing
- Reset values:
  - state=IDLE, NVL=0, CN=0, LIVES=LIVES_INIT, GOALS=0;
  - PLAYING=0, GAMEOVER=0, WIN=0, `start_q`=1.
- Reset asserted mid-game overrides any state on the next edge; CN is never emitted by reset.
- Latency: an event sampled at edge k gives updated counters and new state at edge k+1.
  - CN is high for exactly cycle k+1..k+2.
  - NVL already holds its new value in the CN cycle and stays stable after it.
- CN is never high on two consecutive cycles.
- Minimum spacing between CN strobes is 2 cycles.

## Structure
- Shared package/header holds:
  - state encodings (3-bit localparams);
  - `NVL_MAX = 2**DATAWIDTH_NVL-1`;
  - default LIVES_INIT and GOALS_PER_LEVEL, so lane and display blocks agree on level range.
- One sub-module: `SC_EDGEDETECT` (rising-edge detector, reset-to-1 register) on START_IN.
- The rest is a single FSM plus three counters.

## Test plan
- **Reset then start:** reset with START held high -> no transition. Release, then 1-cycle START -> INIT cycle with CN=1, NVL=0, LIVES=3, then PLAYING=1.
- **Level advance:** 3 GOAL pulses in PLAY -> GOALS 1,2, then ADVANCE cycle with NVL=1, CN=1, GOALS=0, then PLAY.
- **Win:** repeat until NVL=3, then 3 GOALs -> WIN=1, CN stays 0, NVL=3 held. START -> INIT with NVL=0.
- **Lives and game over:** 2 HITs -> two RELOAD cycles, each with CN=1, NVL unchanged, LIVES 2 then 1. 3rd HIT -> GAMEOVER=1, LIVES=0, no CN.
- **Simultaneous / ignored events:** GOAL and HIT in the same cycle -> LIVES-1, GOALS unchanged. GOAL during an ADVANCE cycle -> ignored.
- **Mid-game reset:** reset during RELOAD -> next cycle IDLE, all outputs at reset values, CN=0.
